binary_to_bcd_seq: RTL
======================

Name: binary_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), parametrised in input width and output digit count.
- Generalises the fixed 5-bit (carry + 4-bit sum) to two-digit combinational conversion into any WIDTH / DIGITS combination.
- Handshaked start/done interface, so it can sit between an arithmetic unit and the seven-segment display drivers.
- Flags values that do not fit in DIGITS decimal digits.

Parameters:
WIDTH, 8, bit width of unsigned binary input (>=1)
DIGITS, 3, number of BCD output digits (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion of bin_in; sampled only in IDLE
bin_in  input  WIDTH  unsigned binary value; captured on accepting edge only
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid
bcd_out  output  4*DIGITS  packed BCD; digit k at bits [4k+3:4k], k=0 is the units digit
overflow  output  1  bin_in >= 10^DIGITS; valid with done, held with bcd_out

Behaviour:
- One clock (clk). Reset asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, busy=0, done=0, bcd_out=0, overflow=0.
  - Internal shift register, BCD working register, bit counter and sticky overflow all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On a clk edge with start=1: load bin_in into the shift register, clear the working BCD register and sticky overflow, counter=WIDTH, go to SHIFT.
  - With start=0: stay in IDLE.
- SHIFT, one bit per edge:
  - Every working digit >=5 gets +3 (all digits in parallel, 4-bit add, no carry between digits).
  - Then shift {bcd_work, shift_reg} left 1; the binary MSB enters bit 0 of digit 0.
  - The bit shifted out of the top digit (bit 4*DIGITS-1 after add-3) ORs into sticky overflow.
  - Counter decrements.
  - On the edge performing the WIDTH-th shift: register the final working value into bcd_out, register the final sticky value (including this edge's shift-out) into overflow, set done=1, go to DONE.
- DONE: lasts exactly one cycle. done=1 during it. Next edge: done=0, go to IDLE.
- Latency:
  - Accept edge T0.
  - done high in the cycle following edge T0+WIDTH.
  - busy high from after T0 through the DONE cycle inclusive (WIDTH+1 cycles).
  - Back-to-back period is WIDTH+2 cycles.
- start while busy (SHIFT or DONE): ignored, not queued. bin_in changes while busy have no effect.
- bcd_out and overflow change only on the completion edge. Otherwise they hold the last result, including through IDLE and the next conversion.
- Overflow case: bcd_out = bin_in mod 10^DIGITS (exact low digits); overflow=1.
- Every bcd_out digit is always in 0..9.
- Reset mid-conversion: immediate return to reset values; no done pulse; conversion discarded.
- bin_in=0: full WIDTH shifts still performed; result 0, overflow=0.

Test Plan:
- WIDTH=8, DIGITS=3, bin_in=8'd255, 1-cycle start -> done exactly 8 edges after accept; bcd_out=12'h255, overflow=0; busy high 9 cycles.
- WIDTH=8, DIGITS=3, bin_in=0 then bin_in=8'd100 back-to-back (start re-asserted in first IDLE cycle) -> results 12'h000 then 12'h100, overflow=0 both, second done 10 cycles after the first.
- WIDTH=8, DIGITS=2, bin_in=8'd255 -> bcd_out=8'h55, overflow=1. Then bin_in=8'd99 -> bcd_out=8'h99, overflow=0.
- WIDTH=5, DIGITS=2, sweep all bin_in 0..31 -> bcd_out matches the decimal value (e.g. 31 -> 8'h31, 19 -> 8'h19), overflow=0 throughout.
- WIDTH=8, DIGITS=3: start with 8'd42, re-pulse start with 8'd7 mid-SHIFT -> only one done, bcd_out=12'h042; bcd_out holds 12'h042 afterwards while idle.
- Reset mid-conversion: assert rst_n=0 asynchronously at shift 4 of a conversion of 8'd200 -> busy, done, bcd_out and overflow go to 0 immediately with no clock edge; no done after release; a new start with 8'd200 gives 12'h200.

Source files
------------

// File: rtl/binary_to_bcd_seq_if.sv
// Start/done handshake and result bus of the sequential binary-to-BCD converter.
// master drives the request side, slave is the converter.
interface binary_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Result and overflow flag are held until the next completed conversion.
module binary_to_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input logic                clk,
    input logic                rst_n,
    binary_to_bcd_seq_if.slave bus
);
    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BcdW-1:0]  work_q, work_d;
    logic [BcdW-1:0]  adj;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             sticky_next;
    logic [BcdW-1:0]  bcd_q, bcd_d;
    logic             ovf_q, ovf_d;

    // Add-3 correction per digit, independent 4-bit adds with no inter-digit carry.
    always_comb begin
        adj = work_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit means the value needs more than DIGITS digits.
    assign sticky_next = sticky_q | adj[BcdW-1];

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    shift_d  = bus.bin_in;
                    work_d   = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CntW'(WIDTH);
                    state_d  = StShift;
                end
            end
            StShift: begin
                shift_d  = shift_q << 1;
                work_d   = {adj[BcdW-2:0], shift_q[WIDTH-1]};
                sticky_d = sticky_next;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    bcd_d   = {adj[BcdW-2:0], shift_q[WIDTH-1]};
                    ovf_d   = sticky_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
endmodule
